// File: rtl/alu_muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: funct3 op
// encodings and operand-signedness decode.
package alu_muldiv_pkg;

    localparam logic [2:0] MD_OP_MUL    = 3'd0;
    localparam logic [2:0] MD_OP_MULH   = 3'd1;
    localparam logic [2:0] MD_OP_MULHSU = 3'd2;
    localparam logic [2:0] MD_OP_MULHU  = 3'd3;
    localparam logic [2:0] MD_OP_DIV    = 3'd4;
    localparam logic [2:0] MD_OP_DIVU   = 3'd5;
    localparam logic [2:0] MD_OP_REM    = 3'd6;
    localparam logic [2:0] MD_OP_REMU   = 3'd7;

    // MUL keeps raw operands: its low half is the same for signed and unsigned.
    function automatic logic op_a_signed(input logic [2:0] op);
        return (op == MD_OP_MULH) || (op == MD_OP_MULHSU) ||
               (op == MD_OP_DIV)  || (op == MD_OP_REM);
    endfunction

    function automatic logic op_b_signed(input logic [2:0] op);
        return (op == MD_OP_MULH) || (op == MD_OP_DIV) || (op == MD_OP_REM);
    endfunction

endpackage

// File: rtl/alu_muldiv_step.sv
// One combinational iteration: radix-2 shift-add for multiply, restoring
// shift-subtract for divide. {hi, lo} is the accumulator pair.
module alu_muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic            is_div,
    input  logic [XLEN-1:0] hi,
    input  logic [XLEN-1:0] lo,
    input  logic [XLEN-1:0] operand,
    output logic [XLEN-1:0] hi_next,
    output logic [XLEN-1:0] lo_next
);

    logic [XLEN:0]   sum;
    logic [XLEN:0]   rem_s;
    logic [XLEN-1:0] diff;
    logic            q_bit;

    always_comb begin
        sum   = {1'b0, hi} + {1'b0, (lo[0] ? operand : {XLEN{1'b0}})};
        rem_s = {hi, lo[XLEN-1]};
        q_bit = (rem_s >= {1'b0, operand});
        // Truncation is exact whenever q_bit is set, since the remainder stays below the divisor.
        diff  = rem_s[XLEN-1:0] - operand;

        if (is_div) begin
            hi_next = q_bit ? diff : rem_s[XLEN-1:0];
            lo_next = {lo[XLEN-2:0], q_bit};
        end else begin
            hi_next = sum[XLEN:1];
            lo_next = {sum[0], lo[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/alu_muldiv.sv
// Iterative RV M-extension multiply/divide unit for the execute stage.
// Handshake: a transfer happens on a rising edge where valid & ready are both high; each side holds its valid (and payload) until then.
module alu_muldiv
    import alu_muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [2:0]      i_op,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    input  logic            i_flush,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_result,
    output logic [1:0]      dbg_state
);

    localparam int CNT_W = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [CNT_W-1:0] cnt;
    logic [2:0]       op_q;
    logic             sign_a, sign_b;
    logic [XLEN-1:0]  hi_q, lo_q, opnd_q, result_q;
    logic [XLEN-1:0]  step_hi, step_lo;

    logic             accept;
    logic             sa, sb, div_zero, div_ovf, special;
    logic [XLEN-1:0]  abs_a, abs_b, min_neg, special_res;

    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, final_res;

    // Request decode: magnitudes, signs and the cases that skip iteration.
    always_comb begin
        sa       = op_a_signed(i_op) & i_a[XLEN-1];
        sb       = op_b_signed(i_op) & i_b[XLEN-1];
        abs_a    = sa ? -i_a : i_a;
        abs_b    = sb ? -i_b : i_b;
        min_neg  = {1'b1, {(XLEN-1){1'b0}}};
        div_zero = i_op[2] && (i_b == '0);
        div_ovf  = ((i_op == MD_OP_DIV) || (i_op == MD_OP_REM)) &&
                   (i_a == min_neg) && (i_b == '1);
        special  = div_zero | div_ovf;

        special_res = '0;
        if (div_zero) begin
            special_res = i_op[1] ? i_a : '1;
        end else if (div_ovf) begin
            special_res = i_op[1] ? '0 : i_a;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        o_ready  = 1'b0;
        o_valid  = 1'b0;
        accept   = 1'b0;
        case (state)
            IDLE: begin
                o_ready = 1'b1;
                if (i_valid && !i_flush) begin
                    accept   = 1'b1;
                    state_nx = special ? DONE : CALC;
                end
            end
            CALC: begin
                if (cnt == CNT_W'(1)) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                o_valid = 1'b1;
                if (i_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (i_flush) begin
            state_nx = IDLE;
        end
    end

    alu_muldiv_step #(.XLEN(XLEN)) u_step (
        .is_div  (op_q[2]),
        .hi      (hi_q),
        .lo      (lo_q),
        .operand (opnd_q),
        .hi_next (step_hi),
        .lo_next (step_lo)
    );

    // Sign fix-up applied to the outcome of the final iteration.
    always_comb begin
        prod     = {step_hi, step_lo};
        prod_fix = (sign_a ^ sign_b) ? -prod : prod;
        quo_fix  = (sign_a ^ sign_b) ? -step_lo : step_lo;
        rem_fix  = sign_a ? -step_hi : step_hi;
        if (!op_q[2]) begin
            final_res = (op_q == MD_OP_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        end else begin
            final_res = op_q[1] ? rem_fix : quo_fix;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt      <= '0;
            op_q     <= '0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            opnd_q   <= '0;
            result_q <= '0;
        end else if (accept) begin
            op_q   <= i_op;
            sign_a <= sa;
            sign_b <= sb;
            hi_q   <= '0;
            lo_q   <= abs_a;
            opnd_q <= abs_b;
            if (special) begin
                result_q <= special_res;
            end else begin
                cnt <= CNT_W'(XLEN);
            end
        end else if ((state == CALC) && !i_flush) begin
            hi_q <= step_hi;
            lo_q <= step_lo;
            cnt  <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
                result_q <= final_res;
            end
        end
    end

    assign o_result  = result_q;
    assign dbg_state = state;

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed and random checks of alu_muldiv with an expected-result queue.
module tb_alu_muldiv;
    import alu_muldiv_pkg::*;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            i_rst, i_valid, i_flush, i_ready;
    logic [2:0]      i_op;
    logic [XLEN-1:0] i_a, i_b;
    logic            o_ready, o_valid;
    logic [XLEN-1:0] o_result;
    logic [1:0]      dbg_state;

    logic [XLEN-1:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_muldiv #(.XLEN(XLEN)) dut (
        .i_clk     (clk),
        .i_rst     (i_rst),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_op      (i_op),
        .i_a       (i_a),
        .i_b       (i_b),
        .i_flush   (i_flush),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_result  (o_result),
        .dbg_state (dbg_state)
    );

    task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Independent reference using wide native arithmetic.
    function automatic logic [XLEN-1:0] model(input logic [2:0] op, input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
        logic signed [63:0] sa64, sb64, ub64, sp;
        logic [63:0] up;
        logic [XLEN-1:0] r;
        sa64 = {{32{a[31]}}, a};
        sb64 = {{32{b[31]}}, b};
        ub64 = {32'b0, b};
        up   = {32'b0, a} * {32'b0, b};
        r    = '0;
        case (op)
            MD_OP_MUL:    r = up[31:0];
            MD_OP_MULH:   begin sp = sa64 * sb64; r = sp[63:32]; end
            MD_OP_MULHSU: begin sp = sa64 * ub64; r = sp[63:32]; end
            MD_OP_MULHU:  r = up[63:32];
            MD_OP_DIV:    begin
                if (b == 0) r = '1;
                else begin sp = sa64 / sb64; r = sp[31:0]; end
            end
            MD_OP_DIVU:   r = (b == 0) ? '1 : a / b;
            MD_OP_REM:    begin
                if (b == 0) r = a;
                else begin sp = sa64 % sb64; r = sp[31:0]; end
            end
            default:      r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic int model_lat(input logic [2:0] op, input logic [XLEN-1:0] a,
                                     input logic [XLEN-1:0] b);
        if (op[2] && b == 0) return 1;
        if ((op == MD_OP_DIV || op == MD_OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return XLEN + 1;
    endfunction

    // Called at a negedge with the unit idle; returns at the negedge of cycle 1.
    task automatic start_op(input logic [2:0] op, input logic [XLEN-1:0] a,
                            input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp);
        check("ready_before_accept", XLEN'(o_ready), 1);
        i_op = op; i_a = a; i_b = b; i_valid = 1'b1;
        exp_q.push_back(exp);
        @(posedge clk);
        @(negedge clk);
        i_valid = 1'b0;
    endtask

    task automatic wait_result(input string tag, input int exp_lat);
        int lat;
        logic [XLEN-1:0] exp;
        lat = 1;
        while (!o_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, XLEN'(lat), XLEN'(exp_lat));
        if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $error("FAIL %s_queue: observed empty expected entry", tag);
        end else begin
            exp = exp_q.pop_front();
            check(tag, o_result, exp);
        end
    endtask

    task automatic release_result();
        i_ready = 1'b1;
        @(negedge clk);
        i_ready = 1'b0;
        check("release_valid_low", XLEN'(o_valid), 0);
        check("release_ready_high", XLEN'(o_ready), 1);
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [XLEN-1:0] a,
                          input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp, input int lat);
        start_op(op, a, b, exp);
        wait_result(tag, lat);
        release_result();
    endtask

    initial begin
        logic seen;
        logic [2:0] rop;
        logic [XLEN-1:0] ra, rb;

        i_rst = 1'b1; i_valid = 1'b0; i_flush = 1'b0; i_ready = 1'b0;
        i_op = '0; i_a = '0; i_b = '0;
        repeat (3) @(negedge clk);
        i_rst = 1'b0;
        check("reset_ready", XLEN'(o_ready), 1);
        check("reset_valid", XLEN'(o_valid), 0);
        check("reset_result", o_result, 0);
        check("reset_state", XLEN'(dbg_state), 0);

        run_op("mul",    MD_OP_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
        run_op("mulh",   MD_OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
        run_op("mulhu",  MD_OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        run_op("mulhsu", MD_OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
        run_op("div",    MD_OP_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33);
        run_op("rem",    MD_OP_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33);
        run_op("divu",   MD_OP_DIVU,   32'd100,       32'd7,         32'd14,        33);
        run_op("remu",   MD_OP_REMU,   32'd100,       32'd7,         32'd2,         33);
        run_op("divu_z", MD_OP_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, 1);
        run_op("rem_z",  MD_OP_REM,    32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 1);
        run_op("div_ov", MD_OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("rem_ov", MD_OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);

        // Backpressure: result held while the consumer stalls; new requests ignored.
        start_op(MD_OP_DIVU, 32'd100, 32'd7, 32'd14);
        wait_result("bp_divu", 33);
        i_op = MD_OP_MUL; i_a = 32'd3; i_b = 32'd4; i_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_valid", XLEN'(o_valid), 1);
            check("bp_result", o_result, 32'd14);
            check("bp_ready", XLEN'(o_ready), 0);
        end
        i_valid = 1'b0;
        release_result();

        // Flush beats a simultaneous request in IDLE.
        i_op = MD_OP_MUL; i_a = 32'd3; i_b = 32'd4; i_valid = 1'b1; i_flush = 1'b1;
        @(negedge clk);
        i_valid = 1'b0; i_flush = 1'b0;
        check("flush_idle_state", XLEN'(dbg_state), 0);
        check("flush_idle_valid", XLEN'(o_valid), 0);

        // Flush at CALC cycle 10.
        start_op(MD_OP_MUL, 32'd123, 32'd456, 32'd56088);
        repeat (9) @(negedge clk);
        i_flush = 1'b1;
        @(negedge clk);
        i_flush = 1'b0;
        void'(exp_q.pop_back());
        check("flush_state", XLEN'(dbg_state), 0);
        check("flush_ready", XLEN'(o_ready), 1);
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (o_valid) seen = 1'b1;
            @(negedge clk);
        end
        check("flush_no_valid", XLEN'(seen), 0);
        run_op("after_flush", MD_OP_MUL, 32'd123, 32'd456, 32'd56088, 33);

        // Reset at CALC cycle 20.
        start_op(MD_OP_DIV, 32'hFFFF_FF00, 32'd3, 32'hFFFF_FFAB);
        repeat (19) @(negedge clk);
        i_rst = 1'b1;
        @(negedge clk);
        i_rst = 1'b0;
        void'(exp_q.pop_back());
        check("rst_ready", XLEN'(o_ready), 1);
        check("rst_valid", XLEN'(o_valid), 0);
        check("rst_result", o_result, 0);
        check("rst_state", XLEN'(dbg_state), 0);
        run_op("after_rst", MD_OP_DIV, 32'hFFFF_FF00, 32'd3, 32'hFFFF_FFAB, 33);

        for (int n = 0; n < 12; n++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom();
            rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom();
            run_op("random", rop, ra, rb, model(rop, ra, rb), model_lat(rop, ra, rb));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
Iterative multi-cycle multiply/divide unit implementing the RV M-extension ops. Generalises the single-cycle integer ALU with a parametrised XLEN and a ready/valid handshake on both sides. It sits beside the ALU in the execute stage. The pipeline stalls while a request is outstanding.

Parameters:
XLEN, 32, operand/result width (any even value >= 8)
CNT_W, $clog2(XLEN)+1, iteration counter width (localparam, derived)

Ports:
i_clk  input  1  clock, all state updates on rising edge
i_rst  input  1  synchronous active-high reset
i_valid  input  1  request present
o_ready  output  1  unit idle, request accepted when i_valid & o_ready
i_op  input  3  op select = funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
i_a  input  XLEN  rs1 operand
i_b  input  XLEN  rs2 operand
i_flush  input  1  abort in-flight op (pipeline flush)
o_valid  output  1  result available
i_ready  input  1  consumer takes result when o_valid & i_ready
o_result  output  XLEN  result; meaningful only while o_valid

Behaviour:
- States: IDLE, CALC, DONE. Reset: state=IDLE, o_ready=1, o_valid=0, o_result=0, counter=0.
- IDLE: o_ready=1. On accept, latch op, operand signs and the magnitudes |a|, |b|.
  - Signed ops use abs of signed operands. MULHSU: only a is signed. Unsigned ops use raw values.
  - Special-case checks run on accept; if none apply, go to CALC with counter=XLEN.
- Special cases (go IDLE->DONE directly, o_valid on the cycle after accept):
  - divisor==0: DIV/DIVU result all-ones; REM/REMU result = i_a.
  - DIV with a = most-negative and b = -1: result = a. REM in the same case: result = 0.
- CALC: one iteration per cycle, exactly XLEN cycles. Counter decrements; leave CALC when the counter reaches 1.
  - Multiply: radix-2 shift-add into a 2*XLEN accumulator.
  - Divide: restoring shift-subtract. Quotient and remainder are XLEN wide. Partial remainder is XLEN+1 bits.
- CALC->DONE: apply sign fix-up to form o_result.
  - Product is negated if the operand signs differ (MULH/MULHSU).
  - Quotient is negated if the signs differ (DIV).
  - Remainder takes the sign of the dividend (REM).
  - MUL selects the low half; MULH* select the high half.
- Latency (normal): accept at cycle 0, o_valid first high at cycle XLEN+1.
- DONE: o_valid=1, o_ready=0. o_result is held stable until i_valid... until o_valid & i_ready, then IDLE.
  - Accept is blocked on the same cycle as the handoff: there are no back-to-back accepts, so the next accept is earliest one cycle later.
- i_flush, any state: next state IDLE, o_valid=0, result discarded.
  - i_flush in IDLE with i_valid blocks the accept (flush wins).
- i_rst mid-operation: identical to the reset values above, on the next edge; i_rst has priority over i_flush.
- i_valid while busy is ignored; the requester holds it until o_ready.
- All arithmetic is unsigned on explicit magnitudes; no X propagation. Unused accumulator bits are 0 at accept.

Decomposition:
- funct3 op encodings go in the shared types header as `MD_OP_MUL.. `MD_OP_REMU defines, alongside the existing ALU op defines.
- State encodings are local to the module.
- One natural sub-module: alu_muldiv_step. It is a combinational single iteration: shift-add or trial-subtract on {acc, operand}, returning the next acc and quotient bit.

Test Plan:
- MUL a=7, b=0xFFFFFFFD -> o_result 0xFFFFFFEB; o_valid first high exactly 33 cycles after accept.
- MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- Divide by zero: DIVU 5/0 -> 0xFFFFFFFF; REM 0xFFFFFFF9/0 -> 0xFFFFFFF9. Overflow: DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0. Each case gives o_valid 1 cycle after accept.
- Backpressure and busy: hold i_ready=0 for 5 cycles in DONE -> o_valid and o_result stable, o_ready=0, new i_valid ignored. Raise i_ready -> IDLE next cycle.
- Flush and reset: i_flush at CALC cycle 10 -> IDLE next cycle, o_valid never asserted, and the next op gives a correct result. i_rst at CALC cycle 20 -> all outputs at reset values.
